// File: rtl/bin2seg_dual.sv
// bin2seg_dual: sequential double-dabble binary to two-digit 7-segment converter
module bin2seg_dual #(
  parameter int W = 8,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic [13:0]  both7seg,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sh_q, sh_d;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, ovf_n;
  logic [13:0] seg_q, seg_d;
  logic [6:0] tens_pat;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h40;
    endcase
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_add3
    assign adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  assign ovf_n = |bcd_q[15:8];
  assign tens_pat = (bcd_q[7:4] == 4'd0 && BLANK_LEADING) ? 7'h00 : seg(bcd_q[7:4]);
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    seg_d = seg_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d = value;
        bcd_d = '0;
        cnt_d = 4'(W - 1);
        busy_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? DECODE : SHIFT;
      end
      DECODE: begin
        ovf_d = ovf_n;
        seg_d = ovf_n ? {7'h40, 7'h40} : {tens_pat, seg(bcd_q[3:0])};
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      seg_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      seg_q <= seg_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign both7seg = seg_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bin2seg_dual.sv
// tb_bin2seg_dual: vector table, corner sequences and random values for both blanking modes
module tb_bin2seg_dual;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] value = '0;
  logic busy1, done1, ovf1, busy0, done0, ovf0;
  logic [13:0] seg1, seg0;
  int total = 0, bad = 0;

  bin2seg_dual #(.W(W), .BLANK_LEADING(1'b1)) dut1 (.clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy1), .done(done1), .both7seg(seg1), .ovf(ovf1));
  bin2seg_dual #(.W(W), .BLANK_LEADING(1'b0)) dut0 (.clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy0), .done(done0), .both7seg(seg0), .ovf(ovf0));

  always #5 clk = ~clk;

  typedef struct {int v; logic [13:0] e1; logic [13:0] e0; logic ov;} vec_t;
  vec_t vt[10];
  logic [6:0] digit_seg[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] model(input int v, input bit bl);
    logic [6:0] t;
    if (v > 99) return {1'b1, 7'h40, 7'h40};
    t = (v / 10 == 0 && bl) ? 7'h00 : digit_seg[v / 10];
    return {1'b0, t, digit_seg[v % 10]};
  endfunction

  task automatic run(input int v, output int lat);
    @(negedge clk); value = W'(v); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy1, 1);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done1) begin lat = k; break; end
    end
    chk("latency", lat, W + 1);
    chk("busy_at_done", busy1, 0);
    @(negedge clk);
    chk("done_single", done1, 0);
  endtask

  initial begin
    int lat, cur, prev, cyc, nd;
    logic [14:0] m;
    digit_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vt[0] = '{42,  {7'h66, 7'h5B}, {7'h66, 7'h5B}, 1'b0};
    vt[1] = '{7,   {7'h00, 7'h07}, {7'h3F, 7'h07}, 1'b0};
    vt[2] = '{0,   {7'h00, 7'h3F}, {7'h3F, 7'h3F}, 1'b0};
    vt[3] = '{99,  {7'h6F, 7'h6F}, {7'h6F, 7'h6F}, 1'b0};
    vt[4] = '{100, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b1};
    vt[5] = '{255, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b1};
    vt[6] = '{5,   {7'h00, 7'h6D}, {7'h3F, 7'h6D}, 1'b0};
    vt[7] = '{10,  {7'h06, 7'h3F}, {7'h06, 7'h3F}, 1'b0};
    vt[8] = '{19,  {7'h06, 7'h6F}, {7'h06, 7'h6F}, 1'b0};
    vt[9] = '{80,  {7'h7F, 7'h3F}, {7'h7F, 7'h3F}, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_seg", seg1, 0);
    chk("reset_ovf", ovf1, 0);

    foreach (vt[i]) begin
      run(vt[i].v, lat);
      chk($sformatf("vec_seg1_%0d", vt[i].v), seg1, vt[i].e1);
      chk($sformatf("vec_seg0_%0d", vt[i].v), seg0, vt[i].e0);
      chk($sformatf("vec_ovf_%0d", vt[i].v), ovf1, vt[i].ov);
    end
    repeat (4) @(negedge clk);
    chk("hold_seg", seg1, vt[9].e1);

    // a second start while busy must be dropped
    @(negedge clk); value = 8'd42; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); value = 8'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("busy_start_dones", nd, 1);
    chk("busy_start_seg", seg1, {7'h66, 7'h5B});

    // reset on the 4th shift edge, after an overflowing result
    run(255, lat);
    chk("pre_rst_ovf", ovf1, 1);
    @(negedge clk); value = 8'd88; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", busy1, 0);
    chk("midrst_seg", seg1, 0);
    chk("midrst_ovf", ovf1, 0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run(5, lat);
    chk("post_rst_seg", seg1, {7'h00, 7'h6D});

    // back-to-back sweep 0..99
    @(negedge clk); value = 8'd0; start = 1'b1;
    cur = 0; prev = -1; cyc = 0;
    for (int k = 0; k < 100 * (W + 2) + 50; k++) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (done1) begin
        m = model(cur, 1'b1);
        chk($sformatf("sweep_seg_%0d", cur), seg1, m[13:0]);
        if (prev >= 0) chk("sweep_period", cyc - prev, W + 2);
        prev = cyc;
        cur++;
        if (cur >= 100) break;
        value = W'(cur); start = 1'b1;
      end
    end
    chk("sweep_complete", cur, 100);

    // random values against the arithmetic model
    for (int n = 0; n < 30; n++) begin
      cur = int'($urandom_range(0, 255));
      run(cur, lat);
      m = model(cur, 1'b1);
      chk($sformatf("rnd_seg1_%0d", cur), seg1, m[13:0]);
      chk($sformatf("rnd_ovf_%0d", cur), ovf1, m[14]);
      m = model(cur, 1'b0);
      chk($sformatf("rnd_seg0_%0d", cur), seg0, m[13:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
